// File: rtl/sarray_seq.sv
// sarray_seq: operation sequencer for the systolic array.
// Accepts one TMMA command at a time. It pulls K operand beats and skews the
// per-row/per-column control diagonally onto the left and top array edges.
// It then waits for the wavefront to drain, opens the store-C window and
// pulses done.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   cmd_valid_i/ready_o   command handshake; kminus1/type/precision/acc fields
//   opnd_req_o/cnt_o      operand beat request and index; opnd_gnt_i issues it
//   left_*_o              per-row skewed valid/cnt/type/precision/acc
//   top_valid_o/cnt_o     per-column skewed valid/cnt (same skew as rows)
//   post_storec_valid_o   store-C shift window
//   busy_o, done_o        not-idle flag, one-cycle completion pulse
module sarray_seq #(
  parameter int SARRAY_H = 64,
  parameter int CNT_W    = 8,
  parameter int PREC_W   = 2,
  parameter int PE_LAT   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic [CNT_W-1:0]           cmd_kminus1_i,
  input  logic                       cmd_type_i,
  input  logic [PREC_W-1:0]          cmd_precision_i,
  input  logic                       cmd_acc_i,
  output logic                       opnd_req_o,
  output logic [CNT_W-1:0]           opnd_cnt_o,
  input  logic                       opnd_gnt_i,
  output logic [SARRAY_H-1:0]        left_valid_o,
  output logic [CNT_W*SARRAY_H-1:0]  left_cnt_o,
  output logic [SARRAY_H-1:0]        left_type_o,
  output logic [PREC_W*SARRAY_H-1:0] left_precision_o,
  output logic [SARRAY_H-1:0]        left_acc_o,
  output logic [SARRAY_H-1:0]        top_valid_o,
  output logic [CNT_W*SARRAY_H-1:0]  top_cnt_o,
  output logic                       post_storec_valid_o,
  output logic                       busy_o,
  output logic                       done_o
);

  // Cycles for the last beat to cross the array diagonal and leave the last PE.
  localparam int DRAIN_CYC = 2*SARRAY_H - 2 + PE_LAT;
  localparam int DRAIN_W   = $clog2(DRAIN_CYC + 1);
  localparam int STORE_W   = $clog2(SARRAY_H + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    DRAIN = 3'd2,
    STORE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t              state;
  state_t              next_state;
  logic [CNT_W-1:0]    kminus1;
  logic                cmd_type;
  logic [PREC_W-1:0]   cmd_prec;
  logic                cmd_acc;
  logic [CNT_W-1:0]    beat_cnt;
  logic [DRAIN_W-1:0]  drain_cnt;
  logic [STORE_W-1:0]  store_cnt;
  logic                issue;
  logic                last_beat;

  // A grant counts only while requesting, so a stray grant is ignored.
  assign issue     = (state == ISSUE) && opnd_gnt_i;
  assign last_beat = (beat_cnt == kminus1);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (cmd_valid_i) next_state = ISSUE; else next_state = IDLE;
      ISSUE: if (issue && last_beat) next_state = DRAIN; else next_state = ISSUE;
      DRAIN: if (drain_cnt == {DRAIN_W{1'b0}}) next_state = STORE; else next_state = DRAIN;
      STORE: if (store_cnt == {STORE_W{1'b0}}) next_state = DONE; else next_state = STORE;
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    cmd_ready_o = 1'b0;
    opnd_req_o  = 1'b0;
    opnd_cnt_o  = {CNT_W{1'b0}};
    busy_o      = 1'b1;
    case (state)
      IDLE: begin
        cmd_ready_o = 1'b1;
        busy_o      = 1'b0;
      end
      ISSUE: begin
        opnd_req_o = 1'b1;
        opnd_cnt_o = beat_cnt;
      end
      DRAIN, STORE, DONE: begin
        busy_o = 1'b1;
      end
      default: begin
        busy_o = 1'b1;
      end
    endcase
  end

  // Command latch and the beat / drain / store counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kminus1   <= {CNT_W{1'b0}};
      cmd_type  <= 1'b0;
      cmd_prec  <= {PREC_W{1'b0}};
      cmd_acc   <= 1'b0;
      beat_cnt  <= {CNT_W{1'b0}};
      drain_cnt <= {DRAIN_W{1'b0}};
      store_cnt <= {STORE_W{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            kminus1  <= cmd_kminus1_i;
            cmd_type <= cmd_type_i;
            cmd_prec <= cmd_precision_i;
            cmd_acc  <= cmd_acc_i;
            beat_cnt <= {CNT_W{1'b0}};
          end
        end
        ISSUE: begin
          // Hold at K-1 on the last beat so the counter never wraps.
          if (issue) begin
            if (last_beat) begin
              drain_cnt <= DRAIN_W'(DRAIN_CYC - 1);
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == {DRAIN_W{1'b0}}) begin
            store_cnt <= STORE_W'(SARRAY_H - 1);
          end else begin
            drain_cnt <= drain_cnt - DRAIN_W'(1);
          end
        end
        STORE: begin
          if (store_cnt != {STORE_W{1'b0}}) begin
            store_cnt <= store_cnt - STORE_W'(1);
          end
        end
        default: begin
          store_cnt <= store_cnt;
        end
      endcase
    end
  end

  // Diagonal skew chain: stage 0 takes the issued beat (valid 0 on a bubble),
  // stage r copies stage r-1 every cycle so the wavefront keeps moving in all states.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      left_valid_o     <= {SARRAY_H{1'b0}};
      left_cnt_o       <= {(CNT_W*SARRAY_H){1'b0}};
      left_type_o      <= {SARRAY_H{1'b0}};
      left_precision_o <= {(PREC_W*SARRAY_H){1'b0}};
      left_acc_o       <= {SARRAY_H{1'b0}};
    end else begin
      left_valid_o[0]              <= issue;
      left_cnt_o[CNT_W-1:0]        <= beat_cnt;
      left_type_o[0]               <= cmd_type;
      left_precision_o[PREC_W-1:0] <= cmd_prec;
      left_acc_o[0]                <= cmd_acc;
      for (int r = 1; r < SARRAY_H; r++) begin
        left_valid_o[r]                  <= left_valid_o[r-1];
        left_cnt_o[r*CNT_W +: CNT_W]     <= left_cnt_o[(r-1)*CNT_W +: CNT_W];
        left_type_o[r]                   <= left_type_o[r-1];
        left_precision_o[r*PREC_W +: PREC_W] <= left_precision_o[(r-1)*PREC_W +: PREC_W];
        left_acc_o[r]                    <= left_acc_o[r-1];
      end
    end
  end

  // Columns see exactly the same skew as rows.
  assign top_valid_o = left_valid_o;
  assign top_cnt_o   = left_cnt_o;

  // Registered status pulses, aligned with the STORE and DONE states.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      post_storec_valid_o <= 1'b0;
      done_o              <= 1'b0;
    end else begin
      post_storec_valid_o <= (next_state == STORE);
      done_o              <= (next_state == DONE);
    end
  end

endmodule
